lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit between the MEM pipeline stage and the data memory port.
- Checks alignment for each load/store, builds byte enables and lane-replicated write data, and runs a ready-based handshake to memory so latency can vary.
- Extracts the requested byte/half lane on loads and sign- or zero-extends it.
- Stalls the pipeline until the access completes. Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16, max ACCESS cycles waiting for mem_ready before bus error; 0 disables the timeout.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  access request; held high by the pipeline until cpu_done.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_rwtype  in  2  00 byte, 01 half, 10 word, 11 illegal.
- cpu_sign_extend  in  1  load extension: 1 = sign, 0 = zero.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, right-justified.
- cpu_stall  out  1  freeze pipeline.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  formatted load data.
- cpu_addr_err  out  1  misaligned or illegal type; valid with cpu_done.
- cpu_bus_err  out  1  timeout; valid with cpu_done.
- cpu_bad_addr  out  32  faulting address; valid when either error bit is set.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  32  word-aligned address, bits [1:0] = 00.
- mem_be  out  4  byte enables; bit i = bits [8i+7:8i].
- mem_wdata  out  32  lane-replicated write data.
- mem_rdata  in  32  read word; valid when mem_ready is high.
- mem_ready  in  1  access complete this cycle.

Behaviour:
- Reset: state IDLE, counter 0, all outputs 0.
  - Reset asserted mid-ACCESS drops mem_req asynchronously; the in-flight access is abandoned.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, cpu_req=1, alignment check (combinational):
  - Misaligned when: type 11; half with addr[0]=1; word with addr[1:0]!=00.
  - Misaligned: register cpu_bad_addr and set cpu_addr_err. Go to RESP. No mem_req is issued.
  - Aligned: latch request fields, compute mem_be and mem_wdata, clear counter. Go to ACCESS; mem_req is high from the next cycle.
- Byte enables:
  - Byte: mem_be = 1 << addr[1:0].
  - Half: addr[1]=0 gives 0011, addr[1]=1 gives 1100.
  - Word: 1111.
- Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
- ACCESS:
  - mem_req=1. mem_we, mem_addr, mem_be and mem_wdata stay stable until exit.
  - mem_ready=1: register the formatted load data (loads only), drop mem_req, go to RESP.
  - Otherwise the counter increments. When counter == TIMEOUT-1 and mem_ready=0 (TIMEOUT≠0): set cpu_bus_err, load cpu_bad_addr, drop mem_req, go to RESP.
  - mem_ready and timeout in the same cycle: mem_ready wins.
- Load formatting:
  - Byte: lane addr[1:0].
  - Half: lane addr[1].
  - Extension: 24 or 16 upper bits = cpu_sign_extend & lane MSB.
  - Word: no change.
- RESP: cpu_done=1 for exactly 1 cycle, then go to IDLE. cpu_req is ignored in RESP.
- Error and data hold rules:
  - Error bits are cleared when the next request is accepted.
  - cpu_rdata holds its value until the next load completes.
  - Stores leave cpu_rdata unchanged.
- cpu_stall = (state==ACCESS) | (state==IDLE & cpu_req). It is low in RESP, so the pipeline advances on the done edge.
- Latency: with mem_ready in the first ACCESS cycle, cpu_done rises 2 cycles after cpu_req; with an error, 1 cycle.
- mem_ready seen in IDLE or RESP is ignored.
- Back-to-back: a new cpu_req is accepted in the IDLE cycle that follows RESP.

Decomposition:
- Shared package mips_mem_pkg: BYTE_TYPE=2'b00, HALF_TYPE=2'b01, WORD_TYPE=2'b10, and the FSM state encodings. The existing data memory uses the same rwtype constants.
- One combinational sub-module, lsu_lane_fmt: pure functions for byte-enable generation, write replication and load extraction. Reused by a later cache.

Test Plan:
- Store byte, addr 0x1000_0003, wdata 0x0000_00A5, mem_ready on 1st ACCESS cycle -> mem_addr 0x1000_0000, mem_be 1000, mem_wdata 0xA5A5_A5A5, cpu_done at cycle 2.
- Load half, addr 0x1000_0002, sign_extend=1, mem_rdata 0x8001_1234 -> cpu_rdata 0xFFFF_8001. Same with sign_extend=0 -> 0x0000_8001.
- Load word, addr 0x1000_0006 -> no mem_req, cpu_addr_err=1, cpu_bad_addr 0x1000_0006, cpu_done 1 cycle after req. Repeat with rwtype 11 at 0x1000_0000 -> same error behaviour.
- TIMEOUT=4, mem_ready held 0 -> mem_req high exactly 4 cycles, then cpu_bus_err=1 and one cpu_done pulse. mem_ready asserted on the 4th cycle -> normal completion, no bus_err.
- Load byte with mem_ready delayed 3 cycles -> cpu_stall high throughout, mem_* stable, cpu_done 5 cycles after req. rst_n pulled low mid-ACCESS -> mem_req, cpu_stall and cpu_done drop at once; state is IDLE after release.
- Two back-to-back stores (word 0x1000_0000, half 0x1000_0006) -> second mem_req starts the cycle after the first RESP, mem_be 1111 then 1100, no pulse overlap.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared memory-access constants for the MIPS data path.
// Provides the rwtype encodings (shared with the data memory), the LSU FSM
// state type and the alignment helper used when a request is accepted.
package mips_mem_pkg;

  localparam logic [1:0] BYTE_TYPE = 2'b00;
  localparam logic [1:0] HALF_TYPE = 2'b01;
  localparam logic [1:0] WORD_TYPE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  // Type 2'b11 is illegal and is reported the same way as a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] rwtype, input logic [1:0] addr_lo);
    logic mis;
    case (rwtype)
      BYTE_TYPE: mis = 1'b0;
      HALF_TYPE: mis = addr_lo[0];
      WORD_TYPE: mis = (addr_lo != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Byte-lane formatting for a 32-bit little-endian data port (purely combinational).
// Ports: rwtype_i/addr_lo_i/sign_ext_i select the lane; wdata_i -> wdata_o replicated,
//        be_o byte enables, rdata_i -> rdata_o extracted and extended.
module lsu_lane_fmt
  import mips_mem_pkg::*;
(
  input  logic [1:0]  rwtype_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_lane = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];

    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (rwtype_i)
      BYTE_TYPE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_ext_i & byte_lane[7]}}, byte_lane};
      end
      HALF_TYPE: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_ext_i & half_lane[15]}}, half_lane};
      end
      default: begin
        // Word (illegal types never reach memory, so they share this path).
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: MEM stage request -> ready-handshaked data memory port.
// Ports: cpu_* request/stall/done/result side, mem_* memory side.
// Latency 2 cycles req->done with immediate mem_ready, 1 on alignment error; times out after TIMEOUT.
module lsu_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_rwtype,
  input  logic        cpu_sign_extend,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_addr_err,
  output logic        cpu_bus_err,
  output logic [31:0] cpu_bad_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  lsu_state_t       state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q;
  logic [1:0]       rwtype_q;
  logic             sign_q, we_q;
  logic             mem_req_q, done_q, addr_err_q, bus_err_q;
  logic [3:0]       mem_be_q;
  logic [31:0]      mem_wdata_q, rdata_q, bad_addr_q;

  logic        mis;
  logic [1:0]  fmt_rwtype, fmt_addr_lo;
  logic        fmt_sign;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, fmt_rdata;

  // One formatter serves both phases: in IDLE it sees the live request (for
  // byte enables / write data), afterwards the latched request (for load data).
  assign fmt_rwtype  = (state_q == IDLE) ? cpu_rwtype      : rwtype_q;
  assign fmt_addr_lo = (state_q == IDLE) ? cpu_addr[1:0]   : addr_q[1:0];
  assign fmt_sign    = (state_q == IDLE) ? cpu_sign_extend : sign_q;

  lsu_lane_fmt u_fmt (
    .rwtype_i   (fmt_rwtype),
    .addr_lo_i  (fmt_addr_lo),
    .sign_ext_i (fmt_sign),
    .wdata_i    (cpu_wdata),
    .rdata_i    (mem_rdata),
    .be_o       (fmt_be),
    .wdata_o    (fmt_wdata),
    .rdata_o    (fmt_rdata)
  );

  assign mis   = is_misaligned(cpu_rwtype, cpu_addr[1:0]);
  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      rwtype_q    <= '0;
      sign_q      <= 1'b0;
      we_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      bad_addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
            if (mis) begin
              addr_err_q <= 1'b1;
              bad_addr_q <= cpu_addr;
              done_q     <= 1'b1;
              state_q    <= RESP;
            end else begin
              addr_q      <= cpu_addr;
              rwtype_q    <= cpu_rwtype;
              sign_q      <= cpu_sign_extend;
              we_q        <= cpu_we;
              mem_be_q    <= fmt_be;
              mem_wdata_q <= fmt_wdata;
              cnt_q       <= '0;
              mem_req_q   <= 1'b1;
              state_q     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // mem_ready is checked first so a response on the last allowed cycle wins.
          if (mem_ready) begin
            if (!we_q) rdata_q <= fmt_rdata;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= RESP;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            bus_err_q  <= 1'b1;
            bad_addr_q <= addr_q;
            mem_req_q  <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Gated by rst_n so the stall drops immediately when reset hits, even while
  // the pipeline still presents a request.
  assign cpu_stall = rst_n & ((state_q == ACCESS) | ((state_q == IDLE) & cpu_req));

  assign cpu_done     = done_q;
  assign cpu_rdata    = rdata_q;
  assign cpu_addr_err = addr_err_q;
  assign cpu_bus_err  = bus_err_q;
  assign cpu_bad_addr = bad_addr_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = we_q;
  assign mem_addr     = {addr_q[31:2], 2'b00};
  assign mem_be       = mem_be_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed scoreboard bench for lsu_ctrl (TIMEOUT=4).
// Stimulus pushes expected memory transactions and CPU responses; a memory
// responder and a response monitor pop and compare independently.
module tb_lsu_ctrl;

  logic        clk, rst_n;
  logic        cpu_req, cpu_we, cpu_sign_extend;
  logic [1:0]  cpu_rwtype;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall, cpu_done, cpu_addr_err, cpu_bus_err;
  logic [31:0] cpu_rdata, cpu_bad_addr;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          cycles;
    int          start_cyc;
  } mem_txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        addr_err;
    logic        bus_err;
    logic [31:0] bad_addr;
    int          done_cyc;
  } resp_t;

  mem_txn_t mem_q[$];
  resp_t    resp_q[$];

  lsu_ctrl #(.TIMEOUT(4), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_rwtype(cpu_rwtype),
    .cpu_sign_extend(cpu_sign_extend), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .cpu_addr_err(cpu_addr_err), .cpu_bus_err(cpu_bus_err), .cpu_bad_addr(cpu_bad_addr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: raises mem_ready after each transaction's programmed delay.
  initial begin
    mem_txn_t cur;
    bit act = 0;
    int wc = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0BAD_F00D;
    cur = '{we: 1'b0, addr: '0, be: '0, wdata: '0, rdata: '0, delay: 0, cycles: -1, start_cyc: 0};
    forever begin
      @(posedge clk); #1;
      if (mem_req) begin
        if (!act) begin
          if (mem_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_req: got mem_req=1 expected no access (cycle %0d)", cyc);
            cur.delay = 0; cur.cycles = -1;
          end else begin
            cur = mem_q.pop_front();
            chk("mem_start_cycle", cyc, cur.start_cyc);
          end
          act = 1; wc = 0;
        end
        chk("mem_we", mem_we, cur.we);
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_be", mem_be, cur.be);
        chk("mem_wdata", mem_wdata, cur.wdata);
        mem_ready = (wc == cur.delay);
        mem_rdata = mem_ready ? cur.rdata : 32'h0BAD_F00D;
        wc++;
      end else begin
        if (act && cur.cycles >= 0) chk("mem_req_cycles", wc, cur.cycles);
        act = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0BAD_F00D;
      end
    end
  end

  // Response monitor: every done pulse must match the oldest outstanding request.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (cpu_done) begin
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got cpu_done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = resp_q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("cpu_rdata", cpu_rdata, e.rdata);
          chk("cpu_addr_err", cpu_addr_err, e.addr_err);
          chk("cpu_bus_err", cpu_bus_err, e.bus_err);
          chk("stall_at_done", cpu_stall, 1'b0);
          if (e.addr_err || e.bus_err) chk("cpu_bad_addr", cpu_bad_addr, e.bad_addr);
        end
      end else if (resp_q.size() != 0) begin
        chk("stall_while_busy", cpu_stall, 1'b1);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] t, input logic sx, input logic [31:0] addr,
                       input logic [31:0] wd, input bit has_mem, input logic [3:0] ebe, input logic [31:0] ewd,
                       input logic [31:0] mrd, input int dly, input int mcyc, input bit push,
                       input logic [31:0] erd, input logic eae, input logic ebus, input int lat);
    mem_txn_t m;
    resp_t r;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_rwtype = t; cpu_sign_extend = sx;
    cpu_addr = addr; cpu_wdata = wd;
    if (has_mem) begin
      m.we = we; m.addr = {addr[31:2], 2'b00}; m.be = ebe; m.wdata = ewd; m.rdata = mrd;
      m.delay = dly; m.cycles = mcyc; m.start_cyc = cyc + 1;
      mem_q.push_back(m);
    end
    if (push) begin
      r.rdata = erd; r.addr_err = eae; r.bus_err = ebus; r.bad_addr = addr; r.done_cyc = cyc + lat;
      resp_q.push_back(r);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!cpu_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!cpu_done) begin
      checks++; errors++;
      $display("FAIL done_wait: got no cpu_done within 60 cycles expected a pulse");
    end
  endtask

  task automatic drop();
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_rwtype = 2'b00;
    cpu_sign_extend = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_done", cpu_done, 1'b0);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_errs", {cpu_addr_err, cpu_bus_err}, 2'b00);
    chk("rst_bad_addr", cpu_bad_addr, 32'h0);
    chk("rst_mem_be", mem_be, 4'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // we  type   sx    addr           wdata         mem  be       mem_wdata      mem_rdata      dly mcyc push exp_rdata     ae    be    lat
    issue(1'b1, 2'b00, 1'b0, 32'h1000_0003, 32'h0000_00A5, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0,         0, 1, 1, 32'h0000_0000, 1'b0, 1'b0, 2); wait_done(); drop();
    issue(1'b0, 2'b01, 1'b1, 32'h1000_0002, 32'h0,         1, 4'b1100, 32'h0,         32'h8001_1234, 0, 1, 1, 32'hFFFF_8001, 1'b0, 1'b0, 2); wait_done(); drop();
    issue(1'b0, 2'b01, 1'b0, 32'h1000_0002, 32'h0,         1, 4'b1100, 32'h0,         32'h8001_1234, 0, 1, 1, 32'h0000_8001, 1'b0, 1'b0, 2); wait_done(); drop();
    issue(1'b0, 2'b10, 1'b0, 32'h1000_0006, 32'h0,         0, 4'b0000, 32'h0,         32'h0,         0, 0, 1, 32'h0000_8001, 1'b1, 1'b0, 1); wait_done(); drop();
    issue(1'b0, 2'b11, 1'b0, 32'h1000_0000, 32'h0,         0, 4'b0000, 32'h0,         32'h0,         0, 0, 1, 32'h0000_8001, 1'b1, 1'b0, 1); wait_done(); drop();
    // Timeout: mem_ready never comes -> 4 request cycles then bus error.
    issue(1'b0, 2'b10, 1'b0, 32'h1000_0010, 32'h0,         1, 4'b1111, 32'h0,         32'h0,        99, 4, 1, 32'h0000_8001, 1'b0, 1'b1, 5); wait_done(); drop();
    // mem_ready on the 4th (last allowed) cycle wins over the timeout.
    issue(1'b0, 2'b10, 1'b0, 32'h1000_0014, 32'h0,         1, 4'b1111, 32'h0,         32'hDEAD_BEEF, 3, 4, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 5); wait_done(); drop();
    issue(1'b0, 2'b00, 1'b1, 32'h1000_0001, 32'h0,         1, 4'b0010, 32'h0,         32'h1234_80FF, 3, 4, 1, 32'hFFFF_FF80, 1'b0, 1'b0, 5); wait_done(); drop();
    issue(1'b0, 2'b00, 1'b0, 32'h1000_0002, 32'h0,         1, 4'b0100, 32'h0,         32'h00AB_0000, 1, 2, 1, 32'h0000_00AB, 1'b0, 1'b0, 3); wait_done(); drop();

    // Reset in the middle of an access: nothing completes, outputs drop at once.
    issue(1'b0, 2'b10, 1'b0, 32'h1000_0020, 32'h0,         1, 4'b1111, 32'h0,         32'h0,        99, -1, 0, 32'h0,        1'b0, 1'b0, 0);
    @(posedge clk); @(posedge clk); #3;
    chk("pre_rst_mem_req", mem_req, 1'b1);
    rst_n = 1'b0; cpu_req = 1'b0;
    #1;
    chk("async_rst_mem_req", mem_req, 1'b0);
    chk("async_rst_stall", cpu_stall, 1'b0);
    chk("async_rst_done", cpu_done, 1'b0);
    chk("async_rst_rdata", cpu_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 2'b01, 1'b1, 32'h1000_0000, 32'h0,         1, 4'b0011, 32'h0,         32'h0000_7FFF, 0, 1, 1, 32'h0000_7FFF, 1'b0, 1'b0, 2); wait_done(); drop();

    // Back-to-back stores: second request in the IDLE cycle right after RESP.
    issue(1'b1, 2'b10, 1'b0, 32'h1000_0000, 32'h1122_3344, 1, 4'b1111, 32'h1122_3344, 32'h0,         0, 1, 1, 32'h0000_7FFF, 1'b0, 1'b0, 2); wait_done();
    issue(1'b1, 2'b01, 1'b0, 32'h1000_0006, 32'h0000_BEEF, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0,         0, 1, 1, 32'h0000_7FFF, 1'b0, 1'b0, 2); wait_done(); drop();

    repeat (4) @(posedge clk);
    #1;
    chk("mem_q_empty", mem_q.size(), 0);
    chk("resp_q_empty", resp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
